// File: rtl/vreg_bus_pkg.sv
// Shared types and helpers for the vector register bus controller.
package vreg_bus_pkg;

    localparam int MAX_REGS = 16;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        XFER   = 2'd2
    } state_t;

    // One-hot decode of a register index; out-of-range indices decode to zero
    // so a bad index can never light up a strobe.
    function automatic logic [MAX_REGS-1:0] onehot(input int idx, input int num_regs);
        logic [MAX_REGS-1:0] v;
        v = '0;
        if (idx >= 0 && idx < num_regs && idx < MAX_REGS) begin
            v = {{(MAX_REGS-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/vreg_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the requester at ptr has highest priority,
// then ptr+1, ptr+2, ... wrapping. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               any
);

    // Scan requesters starting at the pointer; first valid one wins.
    always_comb begin
        int k;
        k       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!any && valid[k[PTR_W-1:0]]) begin
                any                = 1'b1;
                gnt[k[PTR_W-1:0]]  = 1'b1;
                gnt_idx            = k[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vreg_bus_ctrl.sv
// Scheduler for the shared tristate vector register bus.
// Build option: VREG_BUS_CTRL_SETTLE_EN inserts a SETTLE cycle where only the
// bus driver is enabled before the capture strobe fires (accept-to-done = 2).
// Without it the driver and capture strobes rise together (accept-to-done = 1).
//
//   state  | meaning
//   IDLE   | waiting for a request; grant is combinational from req_valid
//   SETTLE | driver strobe on, capture strobe off (bus settling)
//   XFER   | driver + capture strobes on, done pulse; also the err/NOP cycle
module vreg_bus_ctrl
    import vreg_bus_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [2*NUM_REQ-1:0]         req_op,
    input  logic [IDX_W*NUM_REQ-1:0]     req_src,
    input  logic [IDX_W*NUM_REQ-1:0]     req_dst,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REGS-1:0]          reg_en,
    output logic [NUM_REGS-1:0]          reg_set,
    output logic                         ext_drive,
    output logic                         ext_capture,
    output logic                         done,
    output logic [$clog2(NUM_REQ)-1:0]   done_id,
    output logic                         err,
    output logic                         busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic [IDX_W-1:0]  dst_q, dst_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              bad_q, bad_d;

    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic [NUM_REGS-1:0] reg_set_q, reg_set_d;
    logic                ext_drive_q, ext_drive_d;
    logic                ext_capture_q, ext_capture_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic                idle;

    op_t                 cur_op;
    logic [IDX_W-1:0]    cur_src;
    logic [IDX_W-1:0]    cur_dst;
    logic                cur_bad;

    logic [MAX_REGS-1:0] src_oh;
    logic [MAX_REGS-1:0] dst_oh;
    logic                drv_reg, drv_ext, cap_reg, cap_ext;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_arb (
        .valid   (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign idle      = (state_q == IDLE);
    assign req_ready = (rst_n && idle) ? gnt : '0;
    assign busy      = (state_q != IDLE);

    // Extract the winning request's fields and classify it as legal or not.
    always_comb begin
        cur_op  = op_t'(req_op[2*int'(gnt_idx) +: 2]);
        cur_src = req_src[IDX_W*int'(gnt_idx) +: IDX_W];
        cur_dst = req_dst[IDX_W*int'(gnt_idx) +: IDX_W];
        cur_bad = 1'b0;
        if ((cur_op == OP_MOVE || cur_op == OP_STORE) && int'(cur_src) >= NUM_REGS) cur_bad = 1'b1;
        if ((cur_op == OP_MOVE || cur_op == OP_LOAD) && int'(cur_dst) >= NUM_REGS)  cur_bad = 1'b1;
        if (cur_op == OP_MOVE && cur_src == cur_dst)                                 cur_bad = 1'b1;
    end

    // Next-state: accept in IDLE, latch the request, advance the RR pointer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        id_d    = id_q;
        bad_d   = bad_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    op_d  = cur_op;
                    src_d = cur_src;
                    dst_d = cur_dst;
                    id_d  = gnt_idx;
                    bad_d = cur_bad;
                    if (int'(gnt_idx) == NUM_REQ - 1) ptr_d = '0;
                    else                              ptr_d = gnt_idx + 1'b1;
`ifdef VREG_BUS_CTRL_SETTLE_EN
                    // Errors and NOPs never drive the bus, so they skip settling.
                    if (cur_bad || cur_op == OP_NOP) state_d = XFER;
                    else                             state_d = SETTLE;
`else
                    state_d = XFER;
`endif
                end
            end
            SETTLE:  state_d = XFER;
            XFER:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe decode from the upcoming state so every strobe leaves a flop.
    always_comb begin
        reg_en_d      = '0;
        reg_set_d     = '0;
        ext_drive_d   = 1'b0;
        ext_capture_d = 1'b0;
        done_d        = 1'b0;
        done_id_d     = '0;
        err_d         = 1'b0;
        src_oh        = onehot(int'(src_d), NUM_REGS);
        dst_oh        = onehot(int'(dst_d), NUM_REGS);
        drv_reg       = !bad_d && (op_d == OP_MOVE || op_d == OP_STORE);
        drv_ext       = !bad_d && (op_d == OP_LOAD);
        cap_reg       = !bad_d && (op_d == OP_MOVE || op_d == OP_LOAD);
        cap_ext       = !bad_d && (op_d == OP_STORE);
        if (state_d == SETTLE || state_d == XFER) begin
            if (drv_reg) reg_en_d = src_oh[NUM_REGS-1:0];
            ext_drive_d = drv_ext;
        end
        if (state_d == XFER) begin
            if (cap_reg) reg_set_d = dst_oh[NUM_REGS-1:0];
            ext_capture_d = cap_ext;
            done_d        = 1'b1;
            done_id_d     = id_d;
            err_d         = bad_d;
        end
    end

    // State, latched request and registered strobes; reset discards everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= OP_MOVE;
            src_q         <= '0;
            dst_q         <= '0;
            id_q          <= '0;
            bad_q         <= 1'b0;
            ptr_q         <= '0;
            reg_en_q      <= '0;
            reg_set_q     <= '0;
            ext_drive_q   <= 1'b0;
            ext_capture_q <= 1'b0;
            done_q        <= 1'b0;
            done_id_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            id_q          <= id_d;
            bad_q         <= bad_d;
            ptr_q         <= ptr_d;
            reg_en_q      <= reg_en_d;
            reg_set_q     <= reg_set_d;
            ext_drive_q   <= ext_drive_d;
            ext_capture_q <= ext_capture_d;
            done_q        <= done_d;
            done_id_q     <= done_id_d;
            err_q         <= err_d;
        end
    end

    assign reg_en      = reg_en_q;
    assign reg_set     = reg_set_q;
    assign ext_drive   = ext_drive_q;
    assign ext_capture = ext_capture_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vreg_bus_ctrl.sv
// Directed + constrained-random bench for vreg_bus_ctrl (2 requesters, 4 registers).
module tb_vreg_bus_ctrl;
    import vreg_bus_pkg::*;

`ifdef VREG_BUS_CTRL_SETTLE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_op;
    logic [5:0] req_src;
    logic [5:0] req_dst;
    logic [1:0] req_ready;
    logic [3:0] reg_en;
    logic [3:0] reg_set;
    logic       ext_drive;
    logic       ext_capture;
    logic       done;
    logic [0:0] done_id;
    logic       err;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Index width widened to 3 so out-of-range register indices can be driven.
    vreg_bus_ctrl #(
        .NUM_REQ  (2),
        .NUM_REGS (4),
        .IDX_W    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_ready   (req_ready),
        .reg_en      (reg_en),
        .reg_set     (reg_set),
        .ext_drive   (ext_drive),
        .ext_capture (ext_capture),
        .done        (done),
        .done_id     (done_id),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_assert++;
        assert (obs_v === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic logic [13:0] obs();
        return {reg_en, reg_set, ext_drive, ext_capture, done, done_id, err, busy};
    endfunction

    function automatic logic [13:0] ov(input logic [3:0] en, input logic [3:0] set,
                                       input logic ed, input logic ec, input logic dn,
                                       input logic did, input logic er, input logic bz);
        return {en, set, ed, ec, dn, did, er, bz};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [2:0] s, input logic [2:0] d);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = op;
        req_src[3*i +: 3]  = s;
        req_dst[3*i +: 3]  = d;
    endtask

    // Random-phase bookkeeping
    int         cyc = 0;
    logic       pend = 1'b0;
    int         due = 0;
    logic       pid = 1'b0;
    logic       perr = 1'b0;
    logic       exp_ptr = 1'b0;
    logic [1:0] acc_prev = 2'b00;
    int         n_acc = 0;
    int         n_done = 0;

    task automatic rand_cycle(input bit gen);
        logic       idle_exp;
        logic [1:0] er;
        int         g;
        logic [1:0] op;
        logic [2:0] s, d;
        logic       bad;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!gen) set_req(i, 1'b0, 2'b11, 3'd0, 3'd0);
            else if (acc_prev[i] || !req_valid[i])
                set_req(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)));
        end
        #1;
        cyc++;
        idle_exp = !pend;
        chk("rnd_inv_drive", 32'(($countones(reg_en) + int'(ext_drive)) <= 1), 32'd1);
        chk("rnd_inv_capture", 32'(($countones(reg_set) + int'(ext_capture)) <= 1), 32'd1);
        chk("rnd_busy", busy, !idle_exp);
        if (pend && cyc == due) begin
            chk("rnd_done", {done, done_id, err}, {1'b1, pid, perr});
            pend = 1'b0;
            n_done++;
        end else begin
            chk("rnd_nodone", {done, err}, 2'b00);
        end
        er = 2'b00;
        if (idle_exp) begin
            if (req_valid[exp_ptr])       er[exp_ptr] = 1'b1;
            else if (req_valid[~exp_ptr]) er[~exp_ptr] = 1'b1;
        end
        chk("rnd_ready", req_ready, er);
        if (er != 2'b00) begin
            g   = er[1] ? 1 : 0;
            op  = req_op[2*g +: 2];
            s   = req_src[3*g +: 3];
            d   = req_dst[3*g +: 3];
            bad = ((op == 2'b00 || op == 2'b10) && s >= 3'd4) ||
                  ((op == 2'b00 || op == 2'b01) && d >= 3'd4) ||
                  (op == 2'b00 && s == d);
            pend    = 1'b1;
            pid     = g[0];
            perr    = bad;
            due     = cyc + ((bad || op == 2'b11) ? 1 : LAT);
            exp_ptr = ~g[0];
            n_acc++;
        end
        acc_prev = req_ready;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_src   = '0;
        req_dst   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {req_ready, obs()}, {2'b00, ov(4'h0, 4'h0, 0, 0, 0, 0, 0, 0)});

        // T1: req0 MOVE src=1 dst=2
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, OP_MOVE, 3'd1, 3'd2);
        #1 chk("t1_ready", req_ready, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, OP_MOVE, 3'd1, 3'd2);
        #1;
`ifdef VREG_BUS_CTRL_SETTLE_EN
        chk("t1_settle", obs(), ov(4'b0010, 4'b0000, 0, 0, 0, 0, 0, 1));
        @(negedge clk); #1;
`endif
        chk("t1_xfer", obs(), ov(4'b0010, 4'b0100, 0, 0, 1, 0, 0, 1));
        @(negedge clk); #1;
        chk("t1_idle", obs(), ov(4'h0, 4'h0, 0, 0, 0, 0, 0, 0));

        // T2: req1 NOP, pointer now favours req1
        set_req(1, 1'b1, OP_NOP, 3'd0, 3'd0);
        #1 chk("t2_ready", req_ready, 2'b10);
        @(negedge clk);
        set_req(1, 1'b0, OP_NOP, 3'd0, 3'd0);
        #1 chk("t2_nop_done", obs(), ov(4'h0, 4'h0, 0, 0, 1, 1, 0, 1));
        @(negedge clk); #1;
        chk("t2_idle", obs(), ov(4'h0, 4'h0, 0, 0, 0, 0, 0, 0));

        // T3: both valid continuously, LOAD dst=0 (req0) / STORE src=3 (req1)
        set_req(0, 1'b1, OP_LOAD, 3'd0, 3'd0);
        set_req(1, 1'b1, OP_STORE, 3'd3, 3'd0);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_ready", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            @(negedge clk); #1;
            chk("t3_no_grant", req_ready, 2'b00);
`ifdef VREG_BUS_CTRL_SETTLE_EN
            if (k % 2 == 0) chk("t3_settle_load", obs(), ov(4'h0, 4'h0, 1, 0, 0, 0, 0, 1));
            else            chk("t3_settle_store", obs(), ov(4'b1000, 4'h0, 0, 0, 0, 0, 0, 1));
            @(negedge clk); #1;
            chk("t3_no_grant2", req_ready, 2'b00);
`endif
            if (k % 2 == 0) chk("t3_xfer_load", obs(), ov(4'h0, 4'b0001, 1, 0, 1, 0, 0, 1));
            else            chk("t3_xfer_store", obs(), ov(4'b1000, 4'h0, 0, 1, 1, 1, 0, 1));
            @(negedge clk);
        end
        set_req(0, 1'b0, OP_LOAD, 3'd0, 3'd0);
        set_req(1, 1'b0, OP_STORE, 3'd3, 3'd0);
        #1 chk("t3_idle", {req_ready, obs()}, {2'b00, ov(4'h0, 4'h0, 0, 0, 0, 0, 0, 0)});

        // T4: illegal requests and a STORE with an unused out-of-range dst
        set_req(1, 1'b1, OP_MOVE, 3'd5, 3'd1);
        #1 chk("t4a_ready", req_ready, 2'b10);
        @(negedge clk);
        set_req(1, 1'b0, OP_MOVE, 3'd5, 3'd1);
        #1 chk("t4a_err_src", obs(), ov(4'h0, 4'h0, 0, 0, 1, 1, 1, 1));
        @(negedge clk); #1;
        chk("t4a_idle", obs(), ov(4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
        set_req(0, 1'b1, OP_MOVE, 3'd2, 3'd2);
        #1 chk("t4b_ready", req_ready, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, OP_MOVE, 3'd2, 3'd2);
        #1 chk("t4b_err_same", obs(), ov(4'h0, 4'h0, 0, 0, 1, 0, 1, 1));
        @(negedge clk);
        set_req(1, 1'b1, OP_LOAD, 3'd0, 3'd4);
        #1 chk("t4c_ready", req_ready, 2'b10);
        @(negedge clk);
        set_req(1, 1'b0, OP_LOAD, 3'd0, 3'd4);
        #1 chk("t4c_err_dst", obs(), ov(4'h0, 4'h0, 0, 0, 1, 1, 1, 1));
        @(negedge clk);
        set_req(0, 1'b1, OP_STORE, 3'd2, 3'd7);
        #1 chk("t4d_ready", req_ready, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, OP_STORE, 3'd2, 3'd7);
        #1;
`ifdef VREG_BUS_CTRL_SETTLE_EN
        chk("t4d_settle", obs(), ov(4'b0100, 4'h0, 0, 0, 0, 0, 0, 1));
        @(negedge clk); #1;
`endif
        chk("t4d_xfer", obs(), ov(4'b0100, 4'h0, 0, 1, 1, 0, 0, 1));
        @(negedge clk); #1;

        // T5: reset mid-transfer clears outputs and the RR pointer
        set_req(0, 1'b1, OP_MOVE, 3'd1, 3'd2);
        #1 chk("t5_ready", req_ready, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, OP_MOVE, 3'd1, 3'd2);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t5_reset", {req_ready, obs()}, {2'b00, ov(4'h0, 4'h0, 0, 0, 0, 0, 0, 0)});
        rst_n = 1'b1;
        set_req(0, 1'b1, OP_NOP, 3'd0, 3'd0);
        set_req(1, 1'b1, OP_NOP, 3'd0, 3'd0);
        #1 chk("t5_ptr_zero", req_ready, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, OP_NOP, 3'd0, 3'd0);
        set_req(1, 1'b0, OP_NOP, 3'd0, 3'd0);
        #1 chk("t5_nop_done", obs(), ov(4'h0, 4'h0, 0, 0, 1, 0, 0, 1));
        @(negedge clk); #1;

        // T6: back-to-back MOVE src=0 dst=3 from req0
        set_req(0, 1'b1, OP_MOVE, 3'd0, 3'd3);
        for (int k = 0; k < 2; k++) begin
            #1 chk("t6_ready", req_ready, 2'b01);
            @(negedge clk); #1;
`ifdef VREG_BUS_CTRL_SETTLE_EN
            chk("t6_settle", obs(), ov(4'b0001, 4'h0, 0, 0, 0, 0, 0, 1));
            @(negedge clk); #1;
`endif
            chk("t6_xfer", obs(), ov(4'b0001, 4'b1000, 0, 0, 1, 0, 0, 1));
            @(negedge clk);
        end
        set_req(0, 1'b0, OP_MOVE, 3'd0, 3'd3);

        // Random traffic from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 6; c++) rand_cycle(1'b0);
        chk("rnd_accept_done_count", n_done, n_acc);
        chk("rnd_drained", pend, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
